// File: rtl/conv_unit_ctrl.sv
// conv_unit_ctrl: job sequencer for the conv_unit MAC datapath.
// Walks beats column-major (col, then channel, then sel 0..2) and emits
// registered per-beat MAC/adder/transfer controls one cycle after each beat.
// Optional build macro: CONV_UNIT_CTRL_PERF_EN adds perf_beats/perf_stalls.
module conv_unit_ctrl #(
  parameter int unsigned CH_W       = 8,
  parameter int unsigned COL_W      = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FLUSH_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [COL_W-1:0]      cfg_cols,
  input  logic [DATA_WIDTH-1:0] bias_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  MA_en,
  output logic                  T_en,
  output logic                  T_sel,
  output logic                  dv_out,
  output logic [1:0]            A_sel,
  output logic [DATA_WIDTH-1:0] bias_out,
  output logic                  busy,
  output logic                  done
`ifdef CONV_UNIT_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_beats,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);
  localparam int unsigned SEL_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [FL_W-1:0]       flush_q, flush_d;
  logic [CH_W-1:0]       cfg_ch_q, cfg_ch_d;
  logic [COL_W-1:0]      cfg_cols_q, cfg_cols_d;
  logic [DATA_WIDTH-1:0] bias_q, bias_d;
  logic                  s_ready_q, s_ready_d;
  logic                  ma_en_q, ma_en_d;
  logic                  t_en_q, t_en_d;
  logic [1:0]            a_sel_q, a_sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic beat_acc;
  logic last_beat;

  assign beat_acc  = (state_q == ST_RUN) && s_valid && s_ready_q;
  assign last_beat = (col_q == cfg_cols_q - COL_W'(1)) &&
                     (ch_q == cfg_ch_q - CH_W'(1)) &&
                     (sel_q == SEL_W'(2));

  // Next-state, beat counters and per-beat control decode.
  // The first FLUSH cycle presents the final beat's controls; FLUSH_CYC
  // further drain cycles follow before DONE.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ch_d       = ch_q;
    col_d      = col_q;
    flush_d    = flush_q;
    cfg_ch_d   = cfg_ch_q;
    cfg_cols_d = cfg_cols_q;
    bias_d     = bias_q;
    ma_en_d    = 1'b0;
    t_en_d     = 1'b0;
    a_sel_d    = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          cfg_ch_d   = cfg_ch;
          cfg_cols_d = cfg_cols;
          bias_d     = bias_in;
          sel_d      = '0;
          ch_d       = '0;
          col_d      = '0;
        end
      end
      ST_LOAD: begin
        if ((cfg_ch_q == '0) || (cfg_cols_q == '0)) state_d = ST_DONE;
        else                                        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (beat_acc) begin
          ma_en_d = 1'b1;
          if ((col_q == '0) && (ch_q == '0) && (sel_q == SEL_W'(0)))
            a_sel_d = 2'd2;
          else if ((col_q != '0) && (ch_q == '0) && (sel_q == SEL_W'(1)))
            a_sel_d = 2'd1;
          t_en_d = (col_q >= COL_W'(3)) && (ch_q == '0) && (sel_q == SEL_W'(1));

          if (sel_q == SEL_W'(2)) begin
            sel_d = '0;
            if (ch_q == cfg_ch_q - CH_W'(1)) begin
              ch_d  = '0;
              col_d = col_q + COL_W'(1);
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end

          if (last_beat) begin
            state_d = ST_FLUSH;
            flush_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FL_W'(FLUSH_CYC)) state_d = ST_DONE;
        else                             flush_d = flush_q + FL_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_RUN);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      flush_q    <= '0;
      cfg_ch_q   <= '0;
      cfg_cols_q <= '0;
      bias_q     <= '0;
      s_ready_q  <= 1'b0;
      ma_en_q    <= 1'b0;
      t_en_q     <= 1'b0;
      a_sel_q    <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ch_q       <= ch_d;
      col_q      <= col_d;
      flush_q    <= flush_d;
      cfg_ch_q   <= cfg_ch_d;
      cfg_cols_q <= cfg_cols_d;
      bias_q     <= bias_d;
      s_ready_q  <= s_ready_d;
      ma_en_q    <= ma_en_d;
      t_en_q     <= t_en_d;
      a_sel_q    <= a_sel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign MA_en    = ma_en_q;
  assign dv_out   = ma_en_q;
  assign T_en     = t_en_q;
  assign T_sel    = t_en_q;
  assign A_sel    = a_sel_q;
  assign bias_out = bias_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef CONV_UNIT_CTRL_PERF_EN
  logic [31:0] perf_beats_q, perf_beats_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  // Saturating beat / stall counters, cleared by an accepted start.
  always_comb begin
    perf_beats_d  = perf_beats_q;
    perf_stalls_d = perf_stalls_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_beats_d  = '0;
      perf_stalls_d = '0;
    end else begin
      if (beat_acc && (perf_beats_q != '1))
        perf_beats_d = perf_beats_q + 32'd1;
      if ((state_q == ST_RUN) && !s_valid && (perf_stalls_q != '1))
        perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_beats_q  <= perf_beats_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/conv_unit_ctrl.md
CONV_UNIT_CTRL -- requirements
Module: conv_unit_ctrl

Interface
- REQ-001: Parameter CH_W, default 8, sets the input-channel count width.
- REQ-002: Parameter COL_W, default 10, sets the column count width.
- REQ-003: Parameter DATA_WIDTH, default 16, sets the bias width (FP16).
- REQ-004: Parameter FLUSH_CYC, default 4, is the downstream MAC pipeline drain depth in cycles (must be ≥1).
- REQ-005: clk  in  1  single clock; all logic on its rising edge.
- REQ-006: rstn  in  1  reset, asynchronous, active-low.
- REQ-007: start  in  1  one-cycle request that begins a job; sampled only in IDLE.
- REQ-008: cfg_ch  in  CH_W  number of input channels; sampled on an accepted start.
- REQ-009: cfg_cols  in  COL_W  number of columns; sampled on an accepted start.
- REQ-010: bias_in  in  DATA_WIDTH  layer bias; sampled on an accepted start.
- REQ-011: s_valid  in  1  upstream data/kernel beat available.
- REQ-012: s_ready  out  1  controller accepts a beat.
- REQ-013: MA_en, T_en, T_sel, dv_out  out  1 each  conv_unit controls.
- REQ-014: A_sel  out  2  conv_unit adder select: 0 = self add, 1 = shift, 2 = zero.
- REQ-015: bias_out  out  DATA_WIDTH  latched bias.
- REQ-016: busy, done  out  1 each  job active; one-cycle job-complete pulse.

Function
- REQ-017: The FSM SHALL have five states: IDLE, LOAD, RUN, FLUSH and DONE.
- REQ-018: IDLE SHALL go to LOAD on start, which latches cfg_ch, cfg_cols and bias_in.
- REQ-019: LOAD SHALL go to DONE if the latched cfg_ch or cfg_cols is 0; otherwise it SHALL go to RUN.
- REQ-020: s_ready SHALL be 1 only in RUN; a beat is accepted when s_valid and s_ready are both 1.
- REQ-021: Beats SHALL be ordered by column (outer loop), then channel, then sel 0..2 (inner loop), with beat index = col*3*CH + ch*3 + sel.
- REQ-022: Counters sel, ch and col SHALL advance only on an accepted beat, wrapping sel at 2 and ch at CH-1.
- REQ-023: Every control output SHALL be registered and reflect the beat accepted on the previous cycle (1-cycle latency).
- REQ-024: MA_en and dv_out SHALL both equal 1 for each accepted beat and 0 otherwise (stall cycles hold the MAC).
- REQ-025: A_sel SHALL be 2 for col=0, ch=0, sel=0; 1 for col≥1, ch=0, sel=1; and 0 otherwise; A_sel SHALL be 0 when no beat is accepted.
- REQ-026: T_en and T_sel SHALL both be 1 for col≥3, ch=0, sel=1, and 0 otherwise.
- REQ-027: The last accepted beat (col=COLS-1, ch=CH-1, sel=2) SHALL move the FSM to FLUSH on the following cycle.
- REQ-028: FLUSH SHALL count FLUSH_CYC cycles, then go to DONE.
- REQ-029: DONE SHALL assert done for exactly one cycle, then go to IDLE.
- REQ-030: busy SHALL be 1 in every state except IDLE.
- REQ-031: start SHALL be ignored outside IDLE.
- REQ-032: bias_out SHALL hold its latched value until the next accepted start.

Reset
- REQ-033: rstn low SHALL immediately force the FSM to IDLE and zero all counters and all outputs, including bias_out, regardless of state (mid-job aborts included).
- REQ-034: After rstn deasserts, the first start SHALL be accepted on the first clk edge.

Configuration
- REQ-035: With CONV_UNIT_CTRL_PERF_EN defined, 32-bit outputs perf_beats and perf_stalls SHALL exist; they clear on an accepted start and count, respectively, accepted beats and RUN cycles with s_valid=0, saturating at all-ones.
- REQ-036: Without CONV_UNIT_CTRL_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
- REQ-037: cfg_ch=2, cfg_cols=5, s_valid held 1 -> 30 beats; A_sel=2 on beat 0, A_sel=1 on beat 7, T_en=1 only on beats 19 and 25; done one cycle, FLUSH_CYC+1 cycles after the last control output.
- REQ-038: Same job with s_valid low on every other cycle -> identical control sequence, MA_en=0 in stall gaps; with PERF_EN, perf_beats=30 and perf_stalls=29.
- REQ-039: cfg_cols=0 -> no beats, s_ready never 1, done 2 cycles after start.
- REQ-040: start pulsed during RUN -> ignored; beat count and bias_out unchanged.
- REQ-041: rstn pulsed low at beat 12 -> all outputs 0 asynchronously, state IDLE; next start runs the full 30 beats.
- REQ-042: bias_in=16'h4000 at start, then changed -> bias_out remains 16'h4000 for the whole job.
